// File: rtl/lzc_norm_pipe.sv
// Pipelined leading-zero/one counter with normalising shift and valid/ready stream interface.
// Optional trailing-count support is enabled by defining LZC_TRAILING_EN (adds in_dir).
module lzc_norm_pipe #(
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned LEVELS_PER_STAGE = 2,
  parameter int unsigned TAG_W            = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_mode,
  input  logic [TAG_W-1:0]         in_tag,
`ifdef LZC_TRAILING_EN
  input  logic                     in_dir,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] out_count,
  output logic                     out_zero,
  output logic [WIDTH-1:0]         out_norm,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int unsigned COUNT  = $clog2(WIDTH);
  localparam int unsigned STAGES = (COUNT + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("lzc_norm_pipe: WIDTH must be a power of two >= 2");
  end
  if (LEVELS_PER_STAGE < 1) begin : g_bad_lps
    $error("lzc_norm_pipe: LEVELS_PER_STAGE must be >= 1");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("lzc_norm_pipe: TAG_W must be >= 1");
  end

  logic dir_in;
`ifdef LZC_TRAILING_EN
  assign dir_in = in_dir;
`else
  assign dir_in = 1'b0;
`endif

  // Per-boundary tree state: node n of the current level, node 0 on the MSB side.
  logic [WIDTH-1:0] s_all  [STAGES];
  logic [COUNT-1:0] s_cnt  [STAGES][WIDTH];
  logic [WIDTH-1:0] s_data [STAGES];
  logic [TAG_W-1:0] s_tag  [STAGES];
  logic             s_mode [STAGES];
  logic             s_dir  [STAGES];

  logic [STAGES-1:0] valid_q;
  logic [STAGES:0]   v_chain;
  logic [STAGES-1:0] rdy;

  logic [WIDTH-1:0] scan_word;
  logic [WIDTH-1:0] lvl0_all;

  always_comb begin
    scan_word = in_mode ? ~in_data : in_data;
    lvl0_all  = '0;
    for (int n = 0; n < int'(WIDTH); n++) begin
      lvl0_all[n] = ~(dir_in ? scan_word[n] : scan_word[WIDTH-1-n]);
    end
  end

  assign s_all[0]  = lvl0_all;
  assign s_cnt[0]  = '{default: '0};
  assign s_data[0] = in_data;
  assign s_tag[0]  = in_tag;
  assign s_mode[0] = in_mode;
  assign s_dir[0]  = dir_in;

  assign v_chain = {valid_q, in_valid};

  // Ready unrolled into a reduction so it depends only on stage valids and out_ready.
  for (genvar k = 0; k < int'(STAGES); k++) begin : g_rdy
    assign rdy[k] = out_ready | ~(&valid_q[STAGES-1:k]);
  end

  assign in_ready  = rdy[0];
  assign out_valid = valid_q[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (rdy[k]) valid_q[k] <= v_chain[k];
      end
    end
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    localparam int Lo = k * int'(LEVELS_PER_STAGE) + 1;
    localparam int Hi = ((k + 1) * int'(LEVELS_PER_STAGE) < int'(COUNT)) ?
                        (k + 1) * int'(LEVELS_PER_STAGE) : int'(COUNT);

    logic [WIDTH-1:0] t_all;
    logic [COUNT-1:0] t_cnt [WIDTH];

    // Merging in place is safe: node n reads 2n and 2n+1 before anything at or above n is rewritten.
    always_comb begin
      t_all = s_all[k];
      t_cnt = s_cnt[k];
      for (int l = Lo; l <= Hi; l++) begin
        for (int n = 0; n < int'(WIDTH) / 2; n++) begin
          if (n < (int'(WIDTH) >> l)) begin
            t_cnt[n] = (t_all[2*n] ? t_cnt[2*n+1] : t_cnt[2*n]) |
                       (COUNT'(t_all[2*n]) << (l - 1));
            t_all[n] = t_all[2*n] & t_all[2*n+1];
          end
        end
      end
    end

    if (k == int'(STAGES) - 1) begin : g_out
      logic [COUNT-1:0] cnt_w;
      assign cnt_w = t_all[0] ? '0 : t_cnt[0];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_count <= '0;
          out_zero  <= 1'b0;
          out_norm  <= '0;
          out_tag   <= '0;
        end else if (rdy[k] && v_chain[k]) begin
          out_count <= cnt_w;
          out_zero  <= t_all[0];
          out_norm  <= s_dir[k] ? (s_data[k] >> cnt_w) : (s_data[k] << cnt_w);
          out_tag   <= s_tag[k];
        end
      end
    end else begin : g_reg
      logic [WIDTH-1:0] all_q;
      logic [COUNT-1:0] cnt_q [WIDTH];
      logic [WIDTH-1:0] data_q;
      logic [TAG_W-1:0] tag_q;
      logic             mode_q;
      logic             dir_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          all_q  <= '0;
          cnt_q  <= '{default: '0};
          data_q <= '0;
          tag_q  <= '0;
          mode_q <= 1'b0;
          dir_q  <= 1'b0;
        end else if (rdy[k] && v_chain[k]) begin
          all_q  <= t_all;
          cnt_q  <= t_cnt;
          data_q <= s_data[k];
          tag_q  <= s_tag[k];
          mode_q <= s_mode[k];
          dir_q  <= s_dir[k];
        end
      end

      assign s_all[k+1]  = all_q;
      assign s_cnt[k+1]  = cnt_q;
      assign s_data[k+1] = data_q;
      assign s_tag[k+1]  = tag_q;
      assign s_mode[k+1] = mode_q;
      assign s_dir[k+1]  = dir_q;
    end
  end

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Self-checking bench for lzc_norm_pipe: directed cases plus randomized traffic against a
// queue-based reference model of count, flag, normalisation, ordering and handshake.
module tb_lzc_norm_pipe;

  localparam int W   = 16;
  localparam int LPS = 2;
  localparam int TW  = 4;
  localparam int CW  = $clog2(W);
  localparam int ST  = (CW + LPS - 1) / LPS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_mode = 1'b0;
  logic [TW-1:0] in_tag = '0;
`ifdef LZC_TRAILING_EN
  logic          in_dir = 1'b0;
`endif
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_count;
  logic          out_zero;
  logic [W-1:0]  out_norm;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  lzc_norm_pipe #(
    .WIDTH            (W),
    .LEVELS_PER_STAGE (LPS),
    .TAG_W            (TW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
`ifdef LZC_TRAILING_EN
    .in_dir    (in_dir),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_zero  (out_zero),
    .out_norm  (out_norm),
    .out_tag   (out_tag)
  );

  typedef struct {
    logic [CW-1:0] cnt;
    logic          zero;
    logic [W-1:0]  norm;
    logic [TW-1:0] tag;
    int            acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Count bits equal to the counted value, scanning from the chosen end.
  function automatic exp_t model(input logic [W-1:0] d, input logic m, input logic dr,
                                 input logic [TW-1:0] t, input int acc);
    exp_t e;
    int   n;
    bit   stop;
    n = 0;
    stop = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (!stop && d[dr ? i : W-1-i] == m) n++;
      else stop = 1'b1;
    end
    e.zero = (n == W);
    e.cnt  = e.zero ? '0 : CW'(n);
    e.norm = e.zero ? d : (dr ? d >> n : d << n);
    e.tag  = t;
    e.acc  = acc;
    return e;
  endfunction

  // One clock: drive at negedge, check just after, then advance to the next negedge.
  task automatic cycle(input logic iv, input logic [W-1:0] d, input logic m, input logic dr,
                       input logic [TW-1:0] t, input logic ordy, output bit accepted);
    logic exp_ov;
    logic exp_ir;
    in_valid  = iv;
    in_data   = d;
    in_mode   = m;
    in_tag    = t;
    out_ready = ordy;
`ifdef LZC_TRAILING_EN
    in_dir    = dr;
`endif
    #1;
    exp_ov = (q.size() > 0) && (cyc - q[0].acc >= ST);
    exp_ir = ordy || (q.size() < ST);
    chk("out_valid", out_valid, exp_ov);
    chk("in_ready", in_ready, exp_ir);
    if (exp_ov) begin
      chk("out_count", out_count, q[0].cnt);
      chk("out_zero", out_zero, q[0].zero);
      chk("out_norm", out_norm, q[0].norm);
      chk("out_tag", out_tag, q[0].tag);
      if (ordy) void'(q.pop_front());
    end
    accepted = iv && exp_ir;
    if (accepted) q.push_back(model(d, m, dr, t, cyc));
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input logic ordy);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0, ordy, a);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_count"}, out_count, '0);
    chk({tag, "_zero"}, out_zero, 1'b0);
    chk({tag, "_norm"}, out_norm, '0);
    chk({tag, "_tag"}, out_tag, '0);
  endtask

  initial begin
    bit            acc;
    int            sent;
    int            c;
    logic [W-1:0]  w4 [8];
    logic [W-1:0]  r;
    logic          m;
    logic          dr;

    // Reset state, then release away from a clock edge.
    @(negedge clk);
    #1;
    chk_reset_outputs("rst");
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Directed: mid-word terminator, MSB terminator, all-equal in both modes, mode 1 pattern.
    cycle(1'b1, 16'h0010, 1'b0, 1'b0, 4'd3, 1'b1, acc);
    idle(3, 1'b1);
    cycle(1'b1, 16'h8000, 1'b0, 1'b0, 4'd4, 1'b1, acc);
    idle(3, 1'b1);
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 4'd5, 1'b1, acc);
    cycle(1'b1, 16'hFFFF, 1'b1, 1'b0, 4'd6, 1'b1, acc);
    cycle(1'b1, 16'hF0F0, 1'b1, 1'b0, 4'd7, 1'b1, acc);
    cycle(1'b1, 16'h0001, 1'b0, 1'b0, 4'd8, 1'b1, acc);
    idle(4, 1'b1);

    // Eight back-to-back words with the output stalled for three cycles.
    for (int i = 0; i < 8; i++) w4[i] = W'($urandom) >> $urandom_range(0, 15);
    sent = 0;
    c = 0;
    while (sent < 8 && c < 100) begin
      cycle(1'b1, w4[sent], 1'b0, 1'b0, TW'(sent), !(c >= 3 && c <= 5), acc);
      if (acc) sent++;
      c++;
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1, 1'b1);
    idle(2, 1'b1);

    // Two words in flight, then an asynchronous reset pulse mid-cycle.
    cycle(1'b1, 16'h00F0, 1'b0, 1'b0, 4'd9, 1'b0, acc);
    cycle(1'b1, 16'h0F00, 1'b0, 1'b0, 4'd10, 1'b0, acc);
    idle(1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cyc++;
    idle(5, 1'b1);

`ifdef LZC_TRAILING_EN
    cycle(1'b1, 16'h0100, 1'b0, 1'b1, 4'd11, 1'b1, acc);
    cycle(1'b1, 16'h0100, 1'b0, 1'b0, 4'd12, 1'b1, acc);
    cycle(1'b1, 16'h0000, 1'b0, 1'b1, 4'd13, 1'b1, acc);
    idle(4, 1'b1);
`endif

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      m  = 1'($urandom);
`ifdef LZC_TRAILING_EN
      dr = 1'($urandom);
`else
      dr = 1'b0;
`endif
      r = W'($urandom);
      r = dr ? (r << $urandom_range(0, 16)) : (r >> $urandom_range(0, 16));
      if ($urandom_range(0, 7) == 0) r = '0;
      if (m) r = ~r;
      cycle(1'($urandom_range(0, 3) != 0), r, m, dr, TW'($urandom), $urandom_range(0, 9) < 7,
            acc);
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1, 1'b1);
    idle(2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
